// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: shares one PS/2 byte transmitter/receiver between the init
// sequencer (port 0) and the runtime command path (port 1). It sends the
// command, waits for the ACK with bounded resend retries and collects up to
// three response bytes.
// Optional feature macro: PS2_ARB_ROUNDROBIN_EN (alternate winner on ties).
module ps2_cmd_arbiter #(
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned ACK_TO_TICKS = 70,
    parameter int unsigned TX_TO_TICKS  = 150
) (
    input  logic        qzt_clk,
    input  logic        rst,
    input  logic        tick_100us,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  cmd0,
    input  logic [7:0]  cmd1,
    input  logic [1:0]  nresp0,
    input  logic [1:0]  nresp1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done,
    output logic [1:0]  status,
    output logic [23:0] resp_data,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        rx_en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_err,
    output logic        busy
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned RETRY_W = 8;

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_ERROR  = 8'hFC;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_DEV_ERR = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_ACK,
        RESP,
        FIN,
        DONE
    } state_t;

    state_t               state, state_nx;
    logic [1:0]           nresp_lat, nresp_nx;
    logic [1:0]           idx, idx_nx;
    logic [RETRY_W-1:0]   retry, retry_nx;
    logic [TIMER_W-1:0]   timer, timer_nx;
    logic [7:0]           cmd_nx;
    logic [1:0]           status_nx;
    logic [23:0]          resp_nx;
    logic                 gnt0_nx, gnt1_nx;
    logic                 done_nx, tx_start_nx, rx_en_nx, busy_nx;
    logic                 pick1;
    logic                 retry_ok;
    logic                 prefer1;

`ifdef PS2_ARB_ROUNDROBIN_EN
    logic last_gnt;

    // Remember who was served last; port 1 "last" out of reset so port 0 wins the first tie
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == FIN) begin
            last_gnt <= gnt1;
        end
    end

    assign prefer1 = ~last_gnt;
`else
    assign prefer1 = 1'b0;
`endif

    // State, datapath and registered outputs
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            state     <= IDLE;
            nresp_lat <= 2'd0;
            idx       <= 2'd0;
            retry     <= '0;
            timer     <= '0;
            tx_byte   <= 8'd0;
            status    <= 2'd0;
            resp_data <= 24'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done      <= 1'b0;
            tx_start  <= 1'b0;
            rx_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            nresp_lat <= nresp_nx;
            idx       <= idx_nx;
            retry     <= retry_nx;
            timer     <= timer_nx;
            tx_byte   <= cmd_nx;
            status    <= status_nx;
            resp_data <= resp_nx;
            gnt0      <= gnt0_nx;
            gnt1      <= gnt1_nx;
            done      <= done_nx;
            tx_start  <= tx_start_nx;
            rx_en     <= rx_en_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state, datapath updates and next output values
    always_comb begin
        state_nx  = state;
        nresp_nx  = nresp_lat;
        idx_nx    = idx;
        retry_nx  = retry;
        cmd_nx    = tx_byte;
        status_nx = status;
        resp_nx   = resp_data;
        gnt0_nx   = gnt0;
        gnt1_nx   = gnt1;
        // Saturating tick counter; per-state clears below override it
        timer_nx  = (tick_100us && (timer != '1)) ? timer + TIMER_W'(1) : timer;
        pick1     = req1 && (!req0 || prefer1);
        retry_ok  = retry < RETRY_W'(MAX_RETRY);

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    cmd_nx   = pick1 ? cmd1 : cmd0;
                    nresp_nx = pick1 ? nresp1 : nresp0;
                    gnt0_nx  = ~pick1;
                    gnt1_nx  = pick1;
                    retry_nx = '0;
                    resp_nx  = 24'd0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                timer_nx = '0;
                state_nx = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    timer_nx = '0;
                    state_nx = WAIT_ACK;
                end else if (timer >= TIMER_W'(TX_TO_TICKS)) begin
                    status_nx = ST_TIMEOUT;
                    state_nx  = FIN;
                end
            end
            WAIT_ACK: begin
                if (rx_valid) begin
                    if (rx_byte == BYTE_ACK) begin
                        if (nresp_lat == 2'd0) begin
                            status_nx = ST_OK;
                            state_nx  = FIN;
                        end else begin
                            timer_nx = '0;
                            idx_nx   = 2'd0;
                            state_nx = RESP;
                        end
                    end else if (rx_byte == BYTE_RESEND) begin
                        if (retry_ok) begin
                            retry_nx = retry + RETRY_W'(1);
                            state_nx = SEND;
                        end else begin
                            status_nx = ST_DEV_ERR;
                            state_nx  = FIN;
                        end
                    end else if (rx_byte == BYTE_ERROR) begin
                        status_nx = ST_DEV_ERR;
                        state_nx  = FIN;
                    end
                end else if (rx_err) begin
                    if (retry_ok) begin
                        retry_nx = retry + RETRY_W'(1);
                        state_nx = SEND;
                    end else begin
                        status_nx = ST_DEV_ERR;
                        state_nx  = FIN;
                    end
                end else if (timer >= TIMER_W'(ACK_TO_TICKS)) begin
                    status_nx = ST_TIMEOUT;
                    state_nx  = FIN;
                end
            end
            RESP: begin
                if (rx_valid) begin
                    resp_nx[{idx, 3'b000} +: 8] = rx_byte;
                    idx_nx   = idx + 2'd1;
                    timer_nx = '0;
                    if ((idx + 2'd1) == nresp_lat) begin
                        status_nx = ST_OK;
                        state_nx  = FIN;
                    end
                end else if (rx_err) begin
                    status_nx = ST_DEV_ERR;
                    state_nx  = FIN;
                end else if (timer >= TIMER_W'(ACK_TO_TICKS)) begin
                    status_nx = ST_TIMEOUT;
                    state_nx  = FIN;
                end
            end
            FIN: begin
                gnt0_nx  = 1'b0;
                gnt1_nx  = 1'b0;
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        done_nx     = (state_nx == FIN);
        tx_start_nx = (state_nx == SEND);
        rx_en_nx    = (state_nx == WAIT_ACK) || (state_nx == RESP);
        busy_nx     = (state_nx != IDLE);
    end

endmodule
